// File: rtl/game_pkg.sv
// Shared types for the game screen sequencer: screen codes, post-blank targets,
// and the frame counter width.
package game_pkg;

  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_BLANK = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  typedef enum logic [1:0] {
    TGT_START    = 2'd0,
    TGT_PLAY_NEW = 2'd1,
    TGT_WIN      = 2'd2,
    TGT_OVER     = 2'd3
  } target_e;

endpackage

// File: rtl/frame_timer.sv
// Frame-paced counter shared by all screens; the owner supplies the terminal
// count for the current screen and clears it on every screen change.
module frame_timer
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic                   clear,
  input  logic [FRAME_CNT_W-1:0] terminal,
  output logic                   tc
);

  logic [FRAME_CNT_W-1:0] count;

  assign tc = frame_start && (count == terminal);

  // Wraps on terminal count so the credit screen can toggle periodically.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (frame_start) begin
      count <= (count == terminal) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Screen/game sequencer: blank, start/credit, play, win and game-over screens,
// with lives/level bookkeeping and one-cycle strobes for the object blocks.
module game_state_controller
  import game_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int NUM_LEVELS    = 3,
  parameter int BLANK_FRAMES  = 30,
  parameter int CREDIT_FRAMES = 240,
  parameter int END_FRAMES    = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_start,
  input  logic       start_key,
  input  logic       player_hit,
  input  logic       level_cleared,
  output logic [2:0] game_state,
  output logic       credit_sel,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic       new_game,
  output logic       new_level,
  output logic       respawn
);

  localparam logic [FRAME_CNT_W-1:0] BLANK_TC  = FRAME_CNT_W'(BLANK_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] CREDIT_TC = FRAME_CNT_W'(CREDIT_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] END_TC    = FRAME_CNT_W'(END_FRAMES - 1);
  localparam logic [2:0]             LIVES_LD  = 3'(LIVES_INIT);
  localparam logic [2:0]             LAST_LVL  = 3'(NUM_LEVELS - 1);

  game_state_e            state, state_nx;
  target_e                target, target_nx;
  logic                   credit_nx;
  logic [2:0]             lives_nx, level_nx;
  logic                   new_game_nx, new_level_nx, respawn_nx;
  logic                   key_prev, key_edge;
  logic                   timer_clear, tc;
  logic [FRAME_CNT_W-1:0] terminal;

  assign key_edge   = start_key && !key_prev;
  assign game_state = state;

  frame_timer u_frame_timer (
    .clk        (clk),
    .resetN     (resetN),
    .frame_start(frame_start),
    .clear      (timer_clear),
    .terminal   (terminal),
    .tc         (tc)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_BLANK;
      target     <= TGT_START;
      credit_sel <= 1'b0;
      lives      <= LIVES_LD;
      level      <= '0;
      new_game   <= 1'b0;
      new_level  <= 1'b0;
      respawn    <= 1'b0;
      key_prev   <= 1'b1;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      credit_sel <= credit_nx;
      lives      <= lives_nx;
      level      <= level_nx;
      new_game   <= new_game_nx;
      new_level  <= new_level_nx;
      respawn    <= respawn_nx;
      key_prev   <= start_key;
    end
  end

  // Level completion outranks a death in the same cycle.
  always_comb begin
    state_nx     = state;
    target_nx    = target;
    credit_nx    = credit_sel;
    lives_nx     = lives;
    level_nx     = level;
    new_game_nx  = 1'b0;
    new_level_nx = 1'b0;
    respawn_nx   = 1'b0;
    terminal     = '0;

    case (state)
      ST_BLANK: begin
        terminal = BLANK_TC;
        if (tc) begin
          case (target)
            TGT_START:    state_nx = ST_START;
            TGT_PLAY_NEW: begin
              state_nx    = ST_PLAY;
              new_game_nx = 1'b1;
              lives_nx    = LIVES_LD;
              level_nx    = '0;
            end
            TGT_WIN:      state_nx = ST_WIN;
            default:      state_nx = ST_OVER;
          endcase
        end
      end
      ST_START: begin
        terminal = CREDIT_TC;
        if (key_edge) begin
          state_nx  = ST_BLANK;
          target_nx = TGT_PLAY_NEW;
          credit_nx = 1'b0;
        end else if (tc) begin
          credit_nx = !credit_sel;
        end
      end
      ST_PLAY: begin
        if (level_cleared) begin
          if (level == LAST_LVL) begin
            state_nx  = ST_BLANK;
            target_nx = TGT_WIN;
          end else begin
            level_nx     = level + 3'd1;
            new_level_nx = 1'b1;
          end
        end else if (player_hit) begin
          if (lives > 3'd1) begin
            lives_nx   = lives - 3'd1;
            respawn_nx = 1'b1;
          end else if (lives == 3'd1) begin
            lives_nx  = '0;
            state_nx  = ST_BLANK;
            target_nx = TGT_OVER;
          end
        end
      end
      ST_WIN, ST_OVER: begin
        terminal = END_TC;
        if (key_edge || tc) begin
          state_nx  = ST_BLANK;
          target_nx = TGT_START;
        end
      end
      default: begin
        state_nx  = ST_BLANK;
        target_nx = TGT_START;
      end
    endcase
  end

  // Any screen change restarts frame pacing, even when a frame pulse lands in the same cycle.
  assign timer_clear = (state_nx != state) || (state == ST_PLAY);

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: a screen-level reference model is compared every
// cycle, plus literal checkpoints along a scripted play-through.
module tb_game_state_controller;

  localparam int LIVES  = 3;
  localparam int LEVELS = 3;
  localparam int BLANK  = 30;
  localparam int CREDIT = 240;
  localparam int ENDF   = 180;

  logic       clk = 1'b0;
  logic       resetN;
  logic       frame_start, start_key, player_hit, level_cleared;
  logic [2:0] game_state, lives, level;
  logic       credit_sel, new_game, new_level, respawn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_state_controller #(
    .LIVES_INIT   (LIVES),
    .NUM_LEVELS   (LEVELS),
    .BLANK_FRAMES (BLANK),
    .CREDIT_FRAMES(CREDIT),
    .END_FRAMES   (ENDF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .frame_start  (frame_start),
    .start_key    (start_key),
    .player_hit   (player_hit),
    .level_cleared(level_cleared),
    .game_state   (game_state),
    .credit_sel   (credit_sel),
    .lives        (lives),
    .level        (level),
    .new_game     (new_game),
    .new_level    (new_level),
    .respawn      (respawn)
  );

  // Screen-level model: which screen is showing, how many frames it has shown,
  // and where the blank screen leads next (target uses the same screen codes).
  typedef struct packed {
    int screen;
    int target;
    int frames;
    bit credit;
    int lives;
    int level;
    bit ng;
    bit nl;
    bit rs;
    bit key;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.screen = 0; r.target = 1; r.frames = 0; r.credit = 1'b0;
    r.lives = LIVES; r.level = 0;
    r.ng = 1'b0; r.nl = 1'b0; r.rs = 1'b0; r.key = 1'b1;
    return r;
  endfunction

  function automatic model_t go_blank(model_t c, int tgt);
    model_t r = c;
    r.screen = 0;
    r.target = tgt;
    r.frames = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, bit fs, bit key, bit hit, bit lc);
    model_t r = c;
    bit pressed = key && !c.key;
    r.key = key;
    r.ng = 1'b0; r.nl = 1'b0; r.rs = 1'b0;
    case (c.screen)
      0: if (fs) begin
        r.frames = c.frames + 1;
        if (r.frames == BLANK) begin
          r.frames = 0;
          r.screen = c.target;
          if (c.target == 2) begin
            r.ng = 1'b1; r.lives = LIVES; r.level = 0;
          end
        end
      end
      1: if (pressed) begin
        r = go_blank(r, 2);
        r.credit = 1'b0;
      end else if (fs) begin
        r.frames = c.frames + 1;
        if (r.frames == CREDIT) begin
          r.frames = 0;
          r.credit = !c.credit;
        end
      end
      2: if (lc) begin
        if (c.level == LEVELS - 1) r = go_blank(r, 3);
        else begin r.level = c.level + 1; r.nl = 1'b1; end
      end else if (hit) begin
        if (c.lives > 1) begin r.lives = c.lives - 1; r.rs = 1'b1; end
        else if (c.lives == 1) begin r.lives = 0; r = go_blank(r, 4); end
      end
      default: if (pressed) r = go_blank(r, 1);
      else if (fs) begin
        r.frames = c.frames + 1;
        if (r.frames == ENDF) r = go_blank(r, 1);
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m <= model_reset();
    else m <= model_next(m, frame_start, start_key, player_hit, level_cleared);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model.game_state", int'(game_state), m.screen);
    checkOutput("model.credit_sel", int'(credit_sel), int'(m.credit));
    checkOutput("model.lives",      int'(lives),      m.lives);
    checkOutput("model.level",      int'(level),      m.level);
    checkOutput("model.new_game",   int'(new_game),   int'(m.ng));
    checkOutput("model.new_level",  int'(new_level),  int'(m.nl));
    checkOutput("model.respawn",    int'(respawn),    int'(m.rs));
  end

  task automatic applyStimulus(input bit fs, input bit hit, input bit lc);
    frame_start   = fs;
    player_hit    = hit;
    level_cleared = lc;
    @(negedge clk);
  endtask

  task automatic runFrames(input int n);
    repeat (n) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pressKey();
    start_key = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic releaseKey();
    start_key = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetN = 1'b0; start_key = 1'b1;
    frame_start = 1'b0; player_hit = 1'b0; level_cleared = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.state", int'(game_state), 0);
    checkOutput("reset.lives", int'(lives), 3);
    checkOutput("reset.level", int'(level), 0);
    resetN = 1'b1;

    // Key held through reset: blank for 30 frames, then start screen, no new game.
    runFrames(29);
    checkOutput("boot.still_blank", int'(game_state), 0);
    runFrames(1);
    checkOutput("boot.start", int'(game_state), 1);
    runFrames(4);
    checkOutput("boot.held_key_ignored", int'(game_state), 1);

    // Credit toggle: four frames already spent in START above.
    runFrames(235);
    checkOutput("credit.before", int'(credit_sel), 0);
    runFrames(1);
    checkOutput("credit.first_toggle", int'(credit_sel), 1);
    runFrames(240);
    checkOutput("credit.second_toggle", int'(credit_sel), 0);

    // New game.
    releaseKey();
    pressKey();
    checkOutput("newgame.blank", int'(game_state), 0);
    runFrames(29);
    checkOutput("newgame.still_blank", int'(game_state), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("newgame.play", int'(game_state), 2);
    checkOutput("newgame.pulse", int'(new_game), 1);
    checkOutput("newgame.lives", int'(lives), 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("newgame.pulse_end", int'(new_game), 0);
    releaseKey();

    // Three deaths -> game over.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hit1.respawn", int'(respawn), 1);
    checkOutput("hit1.lives", int'(lives), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hit2.lives", int'(lives), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hit3.lives", int'(lives), 0);
    checkOutput("hit3.respawn", int'(respawn), 0);
    checkOutput("hit3.blank", int'(game_state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runFrames(30);
    checkOutput("over.state", int'(game_state), 4);
    runFrames(179);
    checkOutput("over.held", int'(game_state), 4);
    runFrames(1);
    checkOutput("over.timeout", int'(game_state), 0);
    runFrames(30);
    checkOutput("over.back_to_start", int'(game_state), 1);

    // Clear all levels -> win, key press leaves early.
    pressKey();
    releaseKey();
    runFrames(30);
    checkOutput("win.play", int'(game_state), 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lvl1.pulse", int'(new_level), 1);
    checkOutput("lvl1.level", int'(level), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lvl2.level", int'(level), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lvl3.blank", int'(game_state), 0);
    checkOutput("lvl3.no_pulse", int'(new_level), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runFrames(30);
    checkOutput("win.state", int'(game_state), 3);
    checkOutput("win.level_held", int'(level), 2);
    pressKey();
    checkOutput("win.key_exit", int'(game_state), 0);
    releaseKey();
    runFrames(30);
    checkOutput("win.back_to_start", int'(game_state), 1);

    // Simultaneous hit and clear with one life left.
    pressKey();
    releaseKey();
    runFrames(30);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("both.lives_before", int'(lives), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("both.level", int'(level), 1);
    checkOutput("both.new_level", int'(new_level), 1);
    checkOutput("both.lives", int'(lives), 1);
    checkOutput("both.respawn", int'(respawn), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midreset.level_before", int'(level), 2);

    // Asynchronous reset between clock edges.
    #2 resetN = 1'b0;
    #1;
    checkOutput("midreset.state", int'(game_state), 0);
    checkOutput("midreset.lives", int'(lives), 3);
    checkOutput("midreset.level", int'(level), 0);
    @(negedge clk);
    resetN = 1'b1;
    runFrames(30);
    checkOutput("midreset.start", int'(game_state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level screen/game sequencer; generates the 3-bit game_state code consumed by the RGB drawing mux.
- Codes: 0 blank, 1 start/credit, 2 playing, 3 win, 4 game over.
- Tracks lives and level, paces screen transitions in VGA frames, and issues one-cycle new_game/new_level/respawn strobes to the object blocks.

Parameters:
LIVES_INIT, 3, lives loaded at new game (1..7)
NUM_LEVELS, 3, levels per game (1..8)
BLANK_FRAMES, 30, frames spent in blank state between screens (1..255)
CREDIT_FRAMES, 240, frames between start-screen/credit-screen toggles (1..255)
END_FRAMES, 180, frames win/game-over screen is held before auto-return (1..255)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse per VGA frame
start_key  in  1  start/fire key level, already synchronised and debounced
player_hit  in  1  one-cycle pulse: player killed
level_cleared  in  1  one-cycle pulse: all level goals met
game_state  out  3  0 blank, 1 start, 2 play, 3 win, 4 over
credit_sel  out  1  in state 1: 0 start screen, 1 credit screen
lives  out  3  remaining lives
level  out  3  current level, 0-based
new_game  out  1  one-cycle pulse on entering play from start
new_level  out  1  one-cycle pulse on advancing level
respawn  out  1  one-cycle pulse on non-fatal hit

Behaviour:
- Clock/reset: clk; reset resetN, asynchronous, active-low. All outputs registered.
- Reset values: game_state=0, next_target=START, frame_cnt=0, credit_sel=0, lives=LIVES_INIT, level=0, all pulses 0, key_prev=1.
- Start-key edge: key_edge = start_key & ~key_prev. key_prev resets to 1, so a key held through reset does not fire.
- BLANK (0):
  - Increment frame_cnt on each frame_start.
  - When frame_cnt==BLANK_FRAMES-1 and frame_start: go to next_target and clear frame_cnt.
  - Entering PLAY from BLANK with next_target=PLAY_NEW: pulse new_game, load lives=LIVES_INIT, level=0. The pulse coincides with the first cycle game_state==2.
  - Key edges are ignored in BLANK.
- START (1):
  - credit_sel toggles every CREDIT_FRAMES frames; frame_cnt wraps at CREDIT_FRAMES-1.
  - key_edge: go to BLANK with next_target=PLAY_NEW, clear frame_cnt, clear credit_sel.
- PLAY (2): events are sampled per cycle. Priority: level_cleared > player_hit.
  - level_cleared, level==NUM_LEVELS-1: go to BLANK with next=WIN.
  - level_cleared, otherwise: level++, pulse new_level next cycle, stay in PLAY.
  - player_hit, lives>1: lives--, pulse respawn.
  - player_hit, lives==1: lives=0, go to BLANK with next=OVER.
  - player_hit, lives==0: cannot occur; ignore.
- WIN (3) / OVER (4):
  - Count frames.
  - On frame END_FRAMES-1 or key_edge, whichever comes first: go to BLANK with next=START.
  - lives and level hold their values for score display.
- Illegal state codes 5–7: recover to BLANK with next=START on the next clock.
- Frame pulse and state change in the same cycle: the transition wins, and frame_cnt is cleared (not incremented).
- Pulses are exactly one cycle wide and never overlap each other.
- Reset mid-game: immediate return to reset values; no pulses are emitted.

Decomposition:
- Package game_pkg: enum of game_state codes (ST_BLANK=0, ST_START=1, ST_PLAY=2, ST_WIN=3, ST_OVER=4), next-target enum (START, PLAY_NEW, WIN, OVER), and the width constant for frame_cnt (8).
- One sub-module: frame_timer. It is a frame_start-driven 8-bit counter with clear and a terminal-count compare input. It is instantiated once and shared by all states, with the terminal count muxed per state.

Test Plan:
- Reset with start_key=1 held → stays blank for 30 frames, then game_state=1; no new_game pulse until the key is released and pressed again.
- In START, idle for 480 frames → credit_sel toggles at frames 240 and 480. Press key → state 0 for 30 frames, then state 2, new_game one cycle, lives=3, level=0.
- In PLAY, three player_hit pulses → first two give respawn with lives 2 then 1. The third gives lives=0, blank for 30 frames, then state 4. After 180 frames: blank, then state 1.
- In PLAY, pulse level_cleared 3 times → new_level pulses with level 1, 2. The third pulse gives blank then state 3. A key press in WIN returns immediately to blank, then state 1.
- player_hit and level_cleared in the same cycle with lives=1, level=0 → level=1, new_level pulses, lives stays 1, no respawn.
- Assert resetN low mid-PLAY (level=2, lives=1) → outputs return to state 0, lives=3, level=0 asynchronously.
